// File: rtl/pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_select_adder
//
// Pipelined WIDTH-bit add/subtract built from BLOCK_SIZE-bit carry-select
// blocks. Each block evaluates two ripple adders in parallel (carry-in 0 and
// carry-in 1) and then selects one of them. BLOCKS_PER_STAGE blocks are
// evaluated per pipeline stage. The carry between blocks ripples across the
// registered stage boundaries. Latency is NUM_STAGES cycles. Throughput is one
// beat per cycle. A single global advance signal stalls the whole pipeline.
//
// Optional feature: define PIPELINED_CARRY_SELECT_ADDER_OVF_EN to add the
// signed-overflow output 'ovf'.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   a beat can be accepted this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry in; ignored when sub=1
//   sub        1 = compute a - b
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result (WIDTH bits)
//   ovf        signed overflow (only with PIPELINED_CARRY_SELECT_ADDER_OVF_EN)
//   cout       carry out of the MSB block; for subtraction 1 = no borrow
// -----------------------------------------------------------------------------
module pipelined_carry_select_adder #(
    parameter int WIDTH            = 32,
    parameter int BLOCK_SIZE       = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CARRY_SELECT_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK_SIZE;
    localparam int NUM_STAGES = (NUM_BLOCKS + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
    localparam int STAGE_BITS = BLOCKS_PER_STAGE * BLOCK_SIZE;

    // Bit-level ripple adder; returns {carry_out, sum}.
    function automatic logic [BLOCK_SIZE:0] ripple_add(
        input logic [BLOCK_SIZE-1:0] x,
        input logic [BLOCK_SIZE-1:0] y,
        input logic                  c
    );
        logic [BLOCK_SIZE:0] r;
        logic                cc;
        r  = '0;
        cc = c;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[BLOCK_SIZE] = cc;
        return r;
    endfunction

    // Carry-select block. Both candidate sums are formed without waiting on
    // the incoming carry. The carry then only drives the final mux.
    function automatic logic [BLOCK_SIZE:0] csel_block(
        input logic [BLOCK_SIZE-1:0] x,
        input logic [BLOCK_SIZE-1:0] y,
        input logic                  c
    );
        logic [BLOCK_SIZE:0] r0;
        logic [BLOCK_SIZE:0] r1;
        r0 = ripple_add(x, y, 1'b0);
        r1 = ripple_add(x, y, 1'b1);
        return c ? r1 : r0;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The whole pipeline moves together. It stalls only when a finished
    // result is waiting at the output and is not being taken.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is resolved at the input. Later stages see a plain add.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : stg
            // LO   = sum bits already completed by earlier stages
            // NB   = blocks in this stage (the last stage may be short)
            // HI   = sum bits completed once this stage is done
            localparam int LO   = k * STAGE_BITS;
            localparam int NB   = (NUM_BLOCKS - k * BLOCKS_PER_STAGE < BLOCKS_PER_STAGE) ?
                                  (NUM_BLOCKS - k * BLOCKS_PER_STAGE) : BLOCKS_PER_STAGE;
            localparam int W    = NB * BLOCK_SIZE;
            localparam int HI   = LO + W;
            localparam bit LAST = (k == NUM_STAGES - 1);

            logic                vld_in;
            logic                cy_in;
            logic [WIDTH-LO-1:0] a_in;
            logic [WIDTH-LO-1:0] b_in;
            logic [W-1:0]        blk_sum;
            logic                cy_nx;
            logic                blk_c;
            logic [BLOCK_SIZE:0] blk_r;
            logic [HI-1:0]       sum_nx;

            logic                vld_p;
            logic                cy_p;
            logic [HI-1:0]       sum_p;

            if (k == 0) begin : g_src
                assign vld_in = in_valid;
                assign cy_in  = cin_eff;
                assign a_in   = a;
                assign b_in   = b_eff;
                assign sum_nx = blk_sum;
            end else begin : g_src
                assign vld_in = stg[k-1].vld_p;
                assign cy_in  = stg[k-1].cy_p;
                assign a_in   = stg[k-1].g_ops.a_p;
                assign b_in   = stg[k-1].g_ops.b_p;
                assign sum_nx = {blk_sum, stg[k-1].sum_p};
            end

            // Combinational evaluation of this stage's blocks. The carry
            // ripples block to block through the select muxes only.
            always_comb begin
                blk_sum = '0;
                blk_r   = '0;
                blk_c   = cy_in;
                for (int j = 0; j < NB; j++) begin
                    blk_r = csel_block(a_in[j*BLOCK_SIZE +: BLOCK_SIZE],
                                       b_in[j*BLOCK_SIZE +: BLOCK_SIZE], blk_c);
                    blk_sum[j*BLOCK_SIZE +: BLOCK_SIZE] = blk_r[BLOCK_SIZE-1:0];
                    blk_c = blk_r[BLOCK_SIZE];
                end
                cy_nx = blk_c;
            end

            // ---- stage k register boundary ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p <= 1'b0;
                end else if (advance) begin
                    vld_p <= vld_in;
                end
            end

            if (LAST) begin : g_out_reg
                // Output register. It is reset so that sum/cout read zero after
                // reset. It loads only real beats, so bubbles never disturb
                // the last presented result.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sum_p <= '0;
                        cy_p  <= 1'b0;
                    end else if (advance && vld_in) begin
                        sum_p <= sum_nx;
                        cy_p  <= cy_nx;
                    end
                end
`ifdef PIPELINED_CARRY_SELECT_ADDER_OVF_EN
                // The operand MSBs arrive here as the top of the carried
                // operand bits. Overflow: equal-sign operands, result sign differs.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf <= 1'b0;
                    end else if (advance && vld_in) begin
                        ovf <= (a_in[WIDTH-LO-1] == b_in[WIDTH-LO-1]) &&
                               (blk_sum[W-1] != a_in[WIDTH-LO-1]);
                    end
                end
`endif
            end else begin : g_ops
                // Operand bits not yet consumed travel with the partial sum.
                logic [WIDTH-HI-1:0] a_p;
                logic [WIDTH-HI-1:0] b_p;
                always_ff @(posedge clk) begin
                    if (advance && vld_in) begin
                        sum_p <= sum_nx;
                        cy_p  <= cy_nx;
                        a_p   <= a_in[WIDTH-LO-1:W];
                        b_p   <= b_in[WIDTH-LO-1:W];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[NUM_STAGES-1].vld_p;
    assign sum       = stg[NUM_STAGES-1].sum_p;
    assign cout      = stg[NUM_STAGES-1].cy_p;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// Testbench for pipelined_carry_select_adder. Configuration: WIDTH=16,
// BLOCK_SIZE=4, BLOCKS_PER_STAGE=2, which gives a latency of 2 cycles.
// Directed vectors with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pipelined_carry_select_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef PIPELINED_CARRY_SELECT_ADDER_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_carry_select_adder #(
        .WIDTH(16),
        .BLOCK_SIZE(4),
        .BLOCKS_PER_STAGE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
`ifdef PIPELINED_CARRY_SELECT_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation. Afterwards the operand inputs are scrambled
    // while in_valid=0, and that must not affect the result.
    task automatic single_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                             input logic tc, input logic ts,
                             input logic [15:0] es, input logic ec, input logic eo);
        a = ta; b = tb_; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tc; sub = ~ts;
        check({tag, ".lat1_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef PIPELINED_CARRY_SELECT_ADDER_OVF_EN
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`endif
        tick();
        check({tag, ".drain_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.sum", {16'd0, sum}, 32'd0);
        check("rst.cout", {31'd0, cout}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPELINED_CARRY_SELECT_ADDER_OVF_EN
        check("rst.ovf", {31'd0, ovf}, 32'd0);
`endif

        // Directed single operations
        single_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single_op("carry_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        single_op("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single_op("sub_nobrw", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        single_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single_op("stage_cy",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Back-to-back throughput: beats i=1..8, result 0x1001*i one cycle apart
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            a = 16'(c + 1);
            b = 16'(16'h1000 * (c + 1));
            check($sformatf("b2b.in_ready%0d", c), {31'd0, in_ready}, 32'd1);
            tick();
            if (c >= 1 && c <= 8) begin
                check($sformatf("b2b.valid%0d", c), {31'd0, out_valid}, 32'd1);
                check($sformatf("b2b.sum%0d", c), {16'd0, sum}, 32'(16'h1001 * c));
            end
        end
        check("b2b.drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: three beats with out_ready held low
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
        tick();
        check("bp.in_ready0", {31'd0, in_ready}, 32'd1);
        a = 16'h0FFF; b = 16'h0001;
        tick();
        check("bp.valid0", {31'd0, out_valid}, 32'd1);
        check("bp.sum0", {16'd0, sum}, 32'h3333);
        check("bp.in_ready_full", {31'd0, in_ready}, 32'd0);
        a = 16'h0010; b = 16'h0001; sub = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("bp.hold_valid%0d", s), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp.hold_sum%0d", s), {16'd0, sum}, 32'h3333);
            check($sformatf("bp.hold_in_ready%0d", s), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp.valid1", {31'd0, out_valid}, 32'd1);
        check("bp.sum1", {16'd0, sum}, 32'h1000);
        check("bp.cout1", {31'd0, cout}, 32'd0);
        tick();
        check("bp.valid2", {31'd0, out_valid}, 32'd1);
        check("bp.sum2", {16'd0, sum}, 32'h000F);
        check("bp.cout2", {31'd0, cout}, 32'd1);
        tick();
        check("bp.drained", {31'd0, out_valid}, 32'd0);

        // Reset mid-operation
        out_ready = 1'b0; sub = 1'b0;
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        tick();
        a = 16'h0001; b = 16'h0001;
        tick();
        check("mid.pre_valid", {31'd0, out_valid}, 32'd1);
        check("mid.pre_sum", {16'd0, sum}, 32'h2345);
        rst = 1'b1; a = 16'h4444; b = 16'h4444;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("mid.rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid.rst_sum", {16'd0, sum}, 32'd0);
        check("mid.rst_cout", {31'd0, cout}, 32'd0);
        check("mid.rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("mid.no_stale_valid%0d", s), {31'd0, out_valid}, 32'd0);
            check($sformatf("mid.no_stale_sum%0d", s), {16'd0, sum}, 32'd0);
        end
        single_op("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
Pipelined, parameterised successor to the combinational carry-select adder. It splits a WIDTH-bit add/subtract into BLOCK_SIZE-bit carry-select blocks and groups BLOCKS_PER_STAGE blocks per pipeline stage. Block carries ripple through registered stage boundaries. Operands enter and results leave over valid/ready handshakes. Throughput is one operation per cycle. It sits on the datapath wherever a wide adder must close timing at high clock rates.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK_SIZE.
- BLOCK_SIZE, 4, bits per carry-select block (dual ripple adders plus mux, as in the existing adder).
- BLOCKS_PER_STAGE, 2, carry-select blocks evaluated per pipeline stage; must be ≥1.
- Derived: NUM_BLOCKS = WIDTH/BLOCK_SIZE; NUM_STAGES = ceil(NUM_BLOCKS/BLOCKS_PER_STAGE).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  1 = compute a − b (b inverted, carry-in forced to 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out. For subtraction, 1 means no borrow.
- ovf  output  1  signed overflow; present only with the optional feature.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear; out_valid=0.
  - sum=0, cout=0, ovf=0 (if present).
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Pipeline control:
  - Global advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_valid/out_ready only, never from in_valid).
  - A beat is accepted when in_valid && in_ready.
  - On advance, every stage register loads from its predecessor; stage 0 loads the input beat (valid bit = in_valid).
  - When advance=0, every stage holds, including data, valid bits, sum, cout and ovf.
  - Bubbles (invalid beats) propagate; they are not squeezed.
- Stage k contents:
  - Evaluates blocks k*BLOCKS_PER_STAGE up to min((k+1)*BLOCKS_PER_STAGE, NUM_BLOCKS)−1.
  - Select carry comes from the registered carry of stage k−1; stage 0 uses the effective carry-in.
  - Stores: the completed low sum bits, the outgoing block carry, and the untouched upper operand bits for later stages.
  - The effective b (inverted when sub=1) and the effective carry-in are fixed at stage 0; sub is not carried further.
- Latency: exactly NUM_STAGES cycles from acceptance to out_valid=1 with no stall. Each stall cycle adds one cycle.
- Arithmetic is modulo 2^WIDTH. cout = carry out of the MSB block.
- Ordering: strictly in order, no drops, no duplication. A result is held stable while out_valid && !out_ready.
- Simultaneous accept and output on the same cycle is legal and sustains 1 beat/cycle.
- Degenerate case: when NUM_BLOCKS is not a multiple of BLOCKS_PER_STAGE, the last stage holds fewer blocks; latency is unchanged.
- Changes to a, b, cin or sub while in_valid=0 have no effect.

Optional Feature:
- Macro: PIPELINED_CARRY_SELECT_ADDER_OVF_EN.
- Defined:
  - Port ovf exists.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is b after inversion for sub.
  - The required MSBs are pipelined alongside the data; ovf is valid with out_valid and is 0 after reset.
- Undefined: port ovf and its pipeline bits do not exist; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=16, BLOCK_SIZE=4, BLOCKS_PER_STAGE=2 (NUM_STAGES=2, latency 2).
1. Add with overflow: a=0x7FFF, b=0x0001, cin=0, sub=0, out_ready=1 → two cycles later: sum=0x8000, cout=0, ovf=1 (with _OVF_EN).
2. Full carry propagation: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Same operands with cin=1 → sum=0x0001, cout=1.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ovf=0. Subtract without borrow: a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
4. Back-to-back throughput: 8 consecutive beats (a=i, b=0x1000·i) with out_ready=1 → 8 results (0x1001·i) on consecutive cycles starting at cycle 2, in order.
5. Backpressure: hold out_ready=0 after 3 beats are issued → in_ready drops once the pipeline is full, out_valid=1 with sum stable. Release out_ready → all 3 results emerge in order, none lost.
6. Reset mid-operation: issue 2 beats, assert rst for 1 cycle → out_valid=0, sum=0, in_ready=1 after reset, and no stale result ever appears.
